// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch.
//   sw_state_t : control FSM states (STOPPED, RUN, LAP)
//   bcd_t      : one BCD digit, always held in the range 0..9
//   SEG_*      : active-low seven-segment patterns, bit 7 = dp (kept dark),
//                bits 6..0 = g f e d c b a
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        LAP     = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to seven-segment decoder.
//   bcd : input digit (0..9; anything else shows blank)
//   seg : active-low segment pattern, bit 7 = dp (always off)
module seg7_decoder
    import stopwatch_pkg::*;
(
    input  bcd_t       bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// Multi-digit BCD stopwatch with start/stop/lap buttons and up/down mode.
//   Clk     : system clock
//   R       : asynchronous active-high reset
//   St      : start button, active-low, asynchronous
//   Stp     : stop button, active-low, asynchronous
//   Lap     : lap button, active-low, asynchronous (freezes/unfreezes display)
//   Dir     : count direction switch, 0 = up, 1 = down
//   HD      : registered segment patterns, digit 0 in HD[7:0], active-low
//   Running : high while counting (RUN or LAP)
//   Wrap    : one-cycle pulse when the counter rolls over 9..9 <-> 0..0
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_HZ     = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clk,
    input  logic                R,
    input  logic                St,
    input  logic                Stp,
    input  logic                Lap,
    input  logic                Dir,
    output logic [8*DIGITS-1:0] HD,
    output logic                Running,
    output logic                Wrap
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(PRESCALE);
    localparam int CW       = $clog2(SYNC_STAGES + 2);

    // ------------------------------------------------------------------
    // Input synchronisers and press detection
    // ------------------------------------------------------------------
    logic [3:0]    raw;
    logic [3:0]    sync_reg [SYNC_STAGES];
    logic [3:0]    synced;
    logic [2:0]    prev_reg;
    logic [CW-1:0] settle_reg;
    logic          settled;
    logic [2:0]    press;
    logic          start_ev;
    logic          stop_ev;
    logic          lap_ev;
    logic          dir_down;

    assign raw    = {Dir, Lap, Stp, St};
    assign synced = sync_reg[SYNC_STAGES-1];

    genvar gi;
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge Clk or posedge R) begin
                if (R) sync_reg[gi] <= '1;
                else   sync_reg[gi] <= raw;
            end
        end else begin : g_rest
            always_ff @(posedge Clk or posedge R) begin
                if (R) sync_reg[gi] <= '1;
                else   sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    end

    // After reset the pipeline is preloaded with "released". A button held
    // through reset would otherwise look like a fresh press once its low
    // level reaches the end of the chain, so presses are ignored until the
    // chain has been completely refilled from the real inputs.
    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            prev_reg   <= '1;
            settle_reg <= '0;
        end else begin
            prev_reg <= synced[2:0];
            if (!settled) settle_reg <= settle_reg + CW'(1);
        end
    end

    assign settled  = (settle_reg == CW'(SYNC_STAGES + 1));
    assign press    = {3{settled}} & prev_reg & ~synced[2:0];
    assign start_ev = press[0];
    assign stop_ev  = press[1];
    assign lap_ev   = press[2];
    assign dir_down = synced[3];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    sw_state_t state_reg, state_next;
    logic      latch_en;
    logic      running;

    always_ff @(posedge Clk or posedge R) begin
        if (R) state_reg <= STOPPED;
        else   state_reg <= state_next;
    end

    // Stop has priority over everything; start is only meaningful when
    // stopped, lap only while counting.
    always_comb begin
        state_next = state_reg;
        latch_en   = 1'b0;
        case (state_reg)
            STOPPED: begin
                if (start_ev && !stop_ev) state_next = RUN;
            end
            RUN: begin
                if (stop_ev) begin
                    state_next = STOPPED;
                end else if (lap_ev) begin
                    state_next = LAP;
                    latch_en   = 1'b1;
                end
            end
            LAP: begin
                if (stop_ev)     state_next = STOPPED;
                else if (lap_ev) state_next = RUN;
            end
            default: state_next = STOPPED;
        endcase
    end

    assign running = (state_reg != STOPPED);

    // ------------------------------------------------------------------
    // Prescaler: frozen while stopped so a restart keeps its phase. The
    // stop press itself also freezes it, so no tick lands on the edge that
    // enters STOPPED.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_reg;
    logic          advance;
    logic          tick;

    assign advance = running && !stop_ev;
    assign tick    = advance && (presc_reg == PW'(PRESCALE - 1));

    always_ff @(posedge Clk or posedge R) begin
        if (R)            presc_reg <= '0;
        else if (advance) presc_reg <= tick ? '0 : presc_reg + PW'(1);
    end

    // ------------------------------------------------------------------
    // BCD counter. up_c[k]/dn_c[k] say that every digit below k is at its
    // limit (9 counting up, 0 counting down), i.e. digit k must step.
    // ------------------------------------------------------------------
    bcd_t          digits_reg [DIGITS];
    bcd_t          latch_reg  [DIGITS];
    logic [7:0]    hd_reg     [DIGITS];
    logic [DIGITS:0] up_c;
    logic [DIGITS:0] dn_c;
    logic          wrap_next;
    logic          wrap_reg;

    always_comb begin
        up_c[0] = 1'b1;
        dn_c[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            up_c[k+1] = up_c[k] & (digits_reg[k] == 4'd9);
            dn_c[k+1] = dn_c[k] & (digits_reg[k] == 4'd0);
        end
    end

    assign wrap_next = tick && (dir_down ? dn_c[DIGITS] : up_c[DIGITS]);

    always_ff @(posedge Clk or posedge R) begin
        if (R) wrap_reg <= 1'b0;
        else   wrap_reg <= wrap_next;
    end

    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_t       d_next;
        bcd_t       disp;
        logic [7:0] seg_w;

        always_comb begin
            d_next = digits_reg[gi];
            if (tick) begin
                if (dir_down) begin
                    if (dn_c[gi]) d_next = (digits_reg[gi] == 4'd0) ? 4'd9 : digits_reg[gi] - 4'd1;
                end else begin
                    if (up_c[gi]) d_next = (digits_reg[gi] == 4'd9) ? 4'd0 : digits_reg[gi] + 4'd1;
                end
            end
        end

        always_ff @(posedge Clk or posedge R) begin
            if (R) begin
                digits_reg[gi] <= '0;
                latch_reg[gi]  <= '0;
            end else begin
                digits_reg[gi] <= d_next;
                // Captures the value shown just before entering LAP.
                if (latch_en) latch_reg[gi] <= digits_reg[gi];
            end
        end

        assign disp = (state_reg == LAP) ? latch_reg[gi] : digits_reg[gi];

        seg7_decoder u_seg (
            .bcd (disp),
            .seg (seg_w)
        );

        always_ff @(posedge Clk or posedge R) begin
            if (R) hd_reg[gi] <= SEG_0;
            else   hd_reg[gi] <= seg_w;
        end

        assign HD[8*gi +: 8] = hd_reg[gi];
    end

    assign Running = running;
    assign Wrap    = wrap_reg;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Randomised scoreboard bench for bcd_stopwatch (2 digits, 4 cycles/count).
// A behavioural model steps once per clock edge from the raw button levels,
// pushes the expected {HD, Running, Wrap}; a monitor pops and compares on the
// falling edge.
module tb_bcd_stopwatch;

    localparam int D    = 2;
    localparam int S    = 2;
    localparam int P    = 4;
    localparam int MAXV = 100;

    logic Clk = 1'b0;
    logic R   = 1'b1;
    logic St  = 1'b1;
    logic Stp = 1'b1;
    logic Lap = 1'b1;
    logic Dir = 1'b0;
    logic [8*D-1:0] HD;
    logic Running;
    logic Wrap;

    bcd_stopwatch #(
        .DIGITS      (D),
        .CLK_HZ      (4),
        .TICK_HZ     (1),
        .SYNC_STAGES (S)
    ) dut (
        .Clk     (Clk),
        .R       (R),
        .St      (St),
        .Stp     (Stp),
        .Lap     (Lap),
        .Dir     (Dir),
        .HD      (HD),
        .Running (Running),
        .Wrap    (Wrap)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [8*D-1:0] hd;
        logic           running;
        logic           wrap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // ---------------- reference model ----------------
    int       m_state;   // 0 stopped, 1 running, 2 running with frozen display
    int       m_val;     // live count as an integer 0..99
    int       m_latch;
    int       m_phase;
    int       m_since;   // clock edges since reset release
    logic [3:0] hist [S+2];  // raw {Dir,Lap,Stp,St} sampled at edges, [0] newest

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [8*D-1:0] hd_of(input int v);
        logic [8*D-1:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[8*i +: 8] = seg_of(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_val   = 0;
        m_latch = 0;
        m_phase = 0;
        m_since = 0;
        for (int i = 0; i < S + 2; i++) hist[i] = 4'hF;
    endtask

    task automatic model_step();
        exp_t e;
        int   ost, ov;
        logic en, ev_st, ev_stp, ev_lap, dn, tk, wr;
        for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {Dir, Lap, Stp, St};
        if (m_since < S + 2) m_since++;
        en     = (m_since >= S + 2);
        ev_st  = en && hist[S+1][0] && !hist[S][0];
        ev_stp = en && hist[S+1][1] && !hist[S][1];
        ev_lap = en && hist[S+1][2] && !hist[S][2];
        dn     = hist[S][3];
        e.hd   = hd_of(m_state == 2 ? m_latch : m_val);
        ost    = m_state;
        ov     = m_val;
        tk     = (ost != 0) && !ev_stp && (m_phase == P - 1);
        if (ost != 0 && !ev_stp) m_phase = (m_phase + 1) % P;
        wr = 1'b0;
        if (tk) begin
            if (!dn) begin
                wr    = (ov == MAXV - 1);
                m_val = (ov + 1) % MAXV;
            end else begin
                wr    = (ov == 0);
                m_val = (ov + MAXV - 1) % MAXV;
            end
        end
        if (ev_stp) m_state = 0;
        else if (ost == 0 && ev_st) m_state = 1;
        else if (ost == 1 && ev_lap) begin
            m_state = 2;
            m_latch = ov;
        end else if (ost == 2 && ev_lap) m_state = 1;
        e.running = (m_state != 0);
        e.wrap    = wr;
        exp_q.push_back(e);
    endtask

    always @(posedge Clk) begin
        cycle++;
        if (R) begin
            model_reset();
            exp_q.push_back({hd_of(0), 1'b0, 1'b0});
        end else begin
            model_step();
        end
    end

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_empty cycle %0d: got no expected entry, required one", cycle);
        end else begin
            e = exp_q.pop_front();
            checks += 3;
            if (HD !== e.hd) begin
                errors++;
                $display("FAIL hd cycle %0d: got %h required %h", cycle, HD, e.hd);
            end
            if (Running !== e.running) begin
                errors++;
                $display("FAIL running cycle %0d: got %b required %b", cycle, Running, e.running);
            end
            if (Wrap !== e.wrap) begin
                errors++;
                $display("FAIL wrap cycle %0d: got %b required %b", cycle, Wrap, e.wrap);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // mask bit 0 = St, 1 = Stp, 2 = Lap
    task automatic press(input logic [2:0] mask, input int hold);
        if (mask[0]) St  = 1'b0;
        if (mask[1]) Stp = 1'b0;
        if (mask[2]) Lap = 1'b0;
        cyc(hold);
        St  = 1'b1;
        Stp = 1'b1;
        Lap = 1'b1;
        cyc(1);
    endtask

    initial begin
        int sel;
        logic [2:0] m;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        #1 R = 1'b0;
        cyc(4);

        Dir = 1'b0;
        press(3'b001, 3);
        cyc(40);
        $display("scenario count_up done, cycle %0d, model value %0d", cycle, m_val);

        Dir = 1'b1;
        cyc(60);
        $display("scenario count_down_wrap done, cycle %0d, model value %0d", cycle, m_val);
        Dir = 1'b0;
        cyc(30);
        $display("scenario count_up_wrap done, cycle %0d, model value %0d", cycle, m_val);

        press(3'b100, 2);
        cyc(14);
        press(3'b100, 2);
        cyc(8);
        press(3'b010, 2);
        cyc(20);
        $display("scenario lap_and_stop done, cycle %0d, model value %0d", cycle, m_val);

        press(3'b001, 2);
        cyc(10);
        press(3'b011, 2);
        cyc(10);
        press(3'b011, 2);
        cyc(10);
        $display("scenario start_stop_same_cycle done, cycle %0d, running %0d", cycle, m_state);

        press(3'b001, 1);
        cyc($urandom_range(3, 12));
        press(3'b010, 1);
        cyc(10);
        press(3'b001, 1);
        cyc(12);
        $display("scenario phase_retained done, cycle %0d, phase %0d", cycle, m_phase);

        cyc(20);
        St = 1'b0;
        cyc(3);
        @(negedge Clk);
        #1 R = 1'b1;
        #1;
        checks++;
        if (Running !== 1'b0 || HD !== hd_of(0)) begin
            errors++;
            $display("FAIL async_reset: got running %b hd %h, required 0 %h", Running, HD, hd_of(0));
        end
        cyc(3);
        @(negedge Clk);
        #1 R = 1'b0;
        cyc(20);
        St = 1'b1;
        cyc(5);
        press(3'b001, 2);
        cyc(20);
        $display("scenario reset_with_held_start done, cycle %0d, model value %0d", cycle, m_val);

        for (int it = 0; it < 250; it++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: m = 3'b001;
                4, 5:       m = 3'b100;
                6:          m = 3'b010;
                7:          m = 3'b011;
                8:          m = 3'b101;
                default:    m = 3'b110;
            endcase
            if ($urandom_range(0, 7) == 0) Dir = ~Dir;
            press(m, $urandom_range(1, 4));
            cyc($urandom_range(1, 15));
        end
        $display("scenario random done, cycle %0d, model value %0d", cycle, m_val);

        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Multi-digit BCD stopwatch/counter for the lab board; successor to the single-digit start/stop/reset timer.
- Parametrised digit count and tick rate; adds up/down mode, lap (display freeze), a wrap pulse and fully synchronous button handling with no latches.
- Sits between the raw push-buttons/switches and the seven-segment displays; one seg7 decoder per digit.

Parameters:
- DIGITS, 4, number of BCD digits (1..8).
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 10, count rate; PRESCALE = CLK_HZ/TICK_HZ cycles per count (integer, >=2).
- SYNC_STAGES, 2, button synchroniser depth (>=2).

Ports:
- Clk  in  1  system clock.
- R  in  1  asynchronous, active-high reset.
- St  in  1  start button, active-low, asynchronous to Clk.
- Stp  in  1  stop button, active-low, asynchronous to Clk.
- Lap  in  1  lap button, active-low, asynchronous to Clk.
- Dir  in  1  level switch: 0 = count up, 1 = count down; synchronised.
- HD  out  8*DIGITS  segment patterns, digit 0 in HD[7:0], active-low segments, bit 7 = dp.
- Running  out  1  high in RUN and LAP states.
- Wrap  out  1  one-cycle pulse on counter wrap-around.

Behaviour:
- Reset (R=1, async): state STOPPED, all digits 0, display latch 0, prescaler 0, Wrap 0, Running 0, synchronisers loaded with 1 (released). HD shows all "0".
- Inputs: St/Stp/Lap/Dir pass through SYNC_STAGES flops; press event = synced value 1->0 (single-cycle pulse per press). Events act on the edge after detection; total button-to-state latency SYNC_STAGES+1 cycles.
- FSM states: STOPPED, RUN, LAP.
  - STOPPED: start -> RUN. Stop/lap ignored.
  - RUN: stop -> STOPPED; lap -> LAP (display latch holds current value).
  - LAP: counting continues, display frozen; lap -> RUN (display tracks live again); stop -> STOPPED with display showing live value.
  - Simultaneous events: stop beats start and lap; start+lap in STOPPED = start only.
- Prescaler: counts 0..PRESCALE-1 only while Running; tick = (prescaler == PRESCALE-1); holds its value in STOPPED (resume keeps phase).
- Counter update on tick, effective next edge:
  - Up: digit 0 increments; digit k carries when all lower digits are 9 (9 -> 0). All digits 9 -> all 0 and Wrap=1 for that same cycle.
  - Down: digit 0 decrements; borrow when all lower digits 0 (0 -> 9). All 0 -> all 9, Wrap=1.
  - Dir sampled on tick cycle; Dir change mid-run takes effect on next tick, no value jump.
- Display: RUN/STOPPED display = live digits; LAP display = latched digits. HD is registered decode of display value (1 cycle after value change). Digits never leave 0..9.
- Wrap is 0 except on wrap cycles; never asserted in STOPPED.
- Reset mid-run: immediate clear of all state, regardless of button levels; held buttons after release of R generate no event until released and pressed again.

Decomposition:
- Shared package stopwatch_pkg: FSM state enum (STOPPED, RUN, LAP), seg7 constants for 0-9 and BLANK, BCD digit typedef (4 bits).
- One sub-module: seg7_decoder (4-bit BCD in, 8-bit active-low segments out), instantiated DIGITS times via generate.
- Synchroniser/edge-detector may be a local generate loop; no separate module required.

Test Plan (DIGITS=2, CLK_HZ=4, TICK_HZ=1 -> PRESCALE=4):
- R pulse then St press, hold Dir=0, 40 cycles -> digits 00,01,... advancing every 4 cycles after start latency; Running=1; HD[7:0] = seg "0".."9" sequence.
- Run from 98 up -> 99 then 00 with Wrap=1 exactly one cycle; Dir=1 from 01 -> 00, 99 with Wrap=1 on 00->99.
- At 05 press Lap -> HD frozen at "05" while live reaches 08; Lap again -> HD shows "08"; Stp -> Running=0, value holds 08 for 20 cycles.
- St and Stp asserted same cycle in RUN -> STOPPED; in STOPPED -> stays STOPPED.
- Assert R mid-run at 37 with St held low -> digits 00, Running=0 immediately; after R release, no count until St released and re-pressed.
- Stop at prescaler phase 2, wait, restart -> first tick occurs 1 cycle after resume (phase retained).
